// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR unit: addresses, op encodings,
// status/interrupt bit positions and the fixed misa value.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  typedef enum logic [1:0] {
    OP_RO = 2'b00,
    OP_RW = 2'b01,
    OP_RS = 2'b10,
    OP_RC = 2'b11
  } csr_op_e;

  localparam int MST_MIE    = 3;
  localparam int MST_MPIE   = 7;
  localparam int MST_MPP_LO = 11;

  // Interrupt cause codes double as the mie/mip bit positions.
  localparam int IRQ_SW  = 3;
  localparam int IRQ_TMR = 7;
  localparam int IRQ_EXT = 11;

  localparam logic [31:0] MISA_VAL = 32'h4000_0100;

  function automatic logic csr_read_only(input logic [11:0] addr);
    return (addr[11:10] == 2'b11) || (addr == CSR_MISA) || (addr == CSR_MIP);
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit event counter with independently writable halves; a write to either
// half suppresses the increment of the whole counter for that cycle.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (wr_lo || wr_hi) begin
      if (wr_lo) q[31:0]  <= wdata;
      if (wr_hi) q[63:32] <= wdata;
    end else if (inc) begin
      q <= q + 64'd1;
    end
  end

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR unit: atomic RMW access, trap/MRET sequencing, interrupt
// pending evaluation and optional 64-bit cycle/instret counters.
module csr_unit
  import csr_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter bit              CNT_EN    = 1'b1,
  parameter logic [XLEN-1:0] MTVEC_RST = '0,
  parameter logic [XLEN-1:0] HART_ID   = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            csr_vld,
  input  logic [1:0]      csr_op,
  input  logic            csr_wen,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  input  logic            trap_vld,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_tval,
  input  logic            mret_vld,
  input  logic            instret_inc,
  input  logic            irq_ext,
  input  logic            irq_tmr,
  input  logic            irq_sw,
  output logic [XLEN-1:0] trap_vector,
  output logic [XLEN-1:0] epc_out,
  output logic            irq_pend
);

  logic            st_mie, st_mpie;
  logic [2:0]      mie_q, mip_q;
  logic [XLEN-1:0] mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [63:0]     cycle_q, instret_q;

  logic [XLEN-1:0] rd_val, new_val, tvec_base;
  logic            impl, illegal, wr_intent, commit;
  logic            cyc_wr_lo, cyc_wr_hi, ins_wr_lo, ins_wr_hi;

  always_comb begin
    rd_val = '0;
    impl   = 1'b1;
    case (csr_addr)
      CSR_MSTATUS: begin
        rd_val[MST_MIE]           = st_mie;
        rd_val[MST_MPIE]          = st_mpie;
        rd_val[MST_MPP_LO +: 2]   = 2'b11;
      end
      CSR_MISA:     rd_val = MISA_VAL;
      CSR_MIE: begin
        rd_val[IRQ_EXT] = mie_q[2];
        rd_val[IRQ_TMR] = mie_q[1];
        rd_val[IRQ_SW]  = mie_q[0];
      end
      CSR_MTVEC:    rd_val = mtvec_q;
      CSR_MSCRATCH: rd_val = mscratch_q;
      CSR_MEPC:     rd_val = mepc_q;
      CSR_MCAUSE:   rd_val = mcause_q;
      CSR_MTVAL:    rd_val = mtval_q;
      CSR_MIP: begin
        rd_val[IRQ_EXT] = mip_q[2];
        rd_val[IRQ_TMR] = mip_q[1];
        rd_val[IRQ_SW]  = mip_q[0];
      end
      CSR_MHARTID:  rd_val = HART_ID;
      CSR_MCYCLE:    if (CNT_EN) rd_val = cycle_q[31:0];    else impl = 1'b0;
      CSR_MCYCLEH:   if (CNT_EN) rd_val = cycle_q[63:32];   else impl = 1'b0;
      CSR_MINSTRET:  if (CNT_EN) rd_val = instret_q[31:0];  else impl = 1'b0;
      CSR_MINSTRETH: if (CNT_EN) rd_val = instret_q[63:32]; else impl = 1'b0;
      default:      impl = 1'b0;
    endcase
  end

  // A reserved op is a plain read, so it never counts as a write attempt.
  assign wr_intent = csr_wen && (csr_op_e'(csr_op) != OP_RO);
  assign illegal   = !impl || (wr_intent && csr_read_only(csr_addr));
  assign commit    = csr_vld && wr_intent && !illegal;

  always_comb begin
    new_val = rd_val;
    case (csr_op_e'(csr_op))
      OP_RW:   new_val = csr_wdata;
      OP_RS:   new_val = rd_val | csr_wdata;
      OP_RC:   new_val = rd_val & ~csr_wdata;
      default: new_val = rd_val;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csr_rdata   <= '0;
      csr_illegal <= 1'b0;
    end else if (csr_vld) begin
      csr_rdata   <= illegal ? '0 : rd_val;
      csr_illegal <= illegal;
    end
  end

  // Trap beats MRET beats a software write, register by register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_mie  <= 1'b0;
      st_mpie <= 1'b0;
    end else if (trap_vld) begin
      st_mpie <= st_mie;
      st_mie  <= 1'b0;
    end else if (mret_vld) begin
      st_mie  <= st_mpie;
      st_mpie <= 1'b1;
    end else if (commit && csr_addr == CSR_MSTATUS) begin
      st_mie  <= new_val[MST_MIE];
      st_mpie <= new_val[MST_MPIE];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mepc_q   <= '0;
      mcause_q <= '0;
      mtval_q  <= '0;
    end else if (trap_vld) begin
      mepc_q   <= {trap_pc[XLEN-1:2], 2'b00};
      mcause_q <= trap_cause;
      mtval_q  <= trap_tval;
    end else if (commit) begin
      if (csr_addr == CSR_MEPC)   mepc_q   <= {new_val[XLEN-1:2], 2'b00};
      if (csr_addr == CSR_MCAUSE) mcause_q <= new_val;
      if (csr_addr == CSR_MTVAL)  mtval_q  <= new_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RST;
      mscratch_q <= '0;
      mip_q      <= '0;
    end else begin
      mip_q <= {irq_ext, irq_tmr, irq_sw};
      if (commit && csr_addr == CSR_MIE)
        mie_q <= {new_val[IRQ_EXT], new_val[IRQ_TMR], new_val[IRQ_SW]};
      // Reserved vector modes (1x) fall back to direct mode.
      if (commit && csr_addr == CSR_MTVEC)
        mtvec_q <= {new_val[XLEN-1:2], new_val[1] ? 2'b00 : new_val[1:0]};
      if (commit && csr_addr == CSR_MSCRATCH)
        mscratch_q <= new_val;
    end
  end

  assign cyc_wr_lo = commit && (csr_addr == CSR_MCYCLE);
  assign cyc_wr_hi = commit && (csr_addr == CSR_MCYCLEH);
  assign ins_wr_lo = commit && (csr_addr == CSR_MINSTRET);
  assign ins_wr_hi = commit && (csr_addr == CSR_MINSTRETH);

  generate
    if (CNT_EN) begin : g_cnt
      csr_counter64 u_mcycle (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (1'b1),
        .wr_lo (cyc_wr_lo),
        .wr_hi (cyc_wr_hi),
        .wdata (new_val),
        .q     (cycle_q)
      );
      csr_counter64 u_minstret (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (instret_inc),
        .wr_lo (ins_wr_lo),
        .wr_hi (ins_wr_hi),
        .wdata (new_val),
        .q     (instret_q)
      );
    end else begin : g_no_cnt
      logic unused_cnt;
      assign unused_cnt = ^{cyc_wr_lo, cyc_wr_hi, ins_wr_lo, ins_wr_hi, instret_inc};
      assign cycle_q    = '0;
      assign instret_q  = '0;
    end
  endgenerate

  assign tvec_base = {mtvec_q[XLEN-1:2], 2'b00};

  always_comb begin
    trap_vector = tvec_base;
    if (mtvec_q[1:0] == 2'b01 && trap_cause[XLEN-1])
      trap_vector = tvec_base + {{(XLEN-7){1'b0}}, trap_cause[4:0], 2'b00};
  end

  assign epc_out  = mepc_q;
  assign irq_pend = st_mie && |(mip_q & mie_q);

endmodule

// File: tb/tb_csr_unit.sv
// Self-checking bench for csr_unit: a per-cycle compare against an address-level
// CSR model, plus directed accesses with hand-computed expectations.
module tb_csr_unit;

  localparam logic [31:0] MTVEC_RST_V = 32'h0000_0080;
  localparam logic [31:0] HART_V      = 32'h0000_0005;

  logic        clk, rst_n;
  logic        csr_vld, csr_wen, trap_vld, mret_vld, instret_inc;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, trap_cause, trap_pc, trap_tval;
  logic        irq_ext, irq_tmr, irq_sw;
  logic [31:0] csr_rdata, trap_vector, epc_out;
  logic        csr_illegal, irq_pend;
  logic [31:0] rdata0, tvec0, epc0;
  logic        ill0, pend0;

  csr_unit #(.XLEN(32), .CNT_EN(1'b1), .MTVEC_RST(MTVEC_RST_V), .HART_ID(HART_V)) u_dut (
    .clk(clk), .rst_n(rst_n), .csr_vld(csr_vld), .csr_op(csr_op), .csr_wen(csr_wen),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .csr_illegal(csr_illegal), .trap_vld(trap_vld), .trap_cause(trap_cause),
    .trap_pc(trap_pc), .trap_tval(trap_tval), .mret_vld(mret_vld),
    .instret_inc(instret_inc), .irq_ext(irq_ext), .irq_tmr(irq_tmr), .irq_sw(irq_sw),
    .trap_vector(trap_vector), .epc_out(epc_out), .irq_pend(irq_pend)
  );

  csr_unit #(.XLEN(32), .CNT_EN(1'b0), .MTVEC_RST(MTVEC_RST_V), .HART_ID(HART_V)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .csr_vld(csr_vld), .csr_op(csr_op), .csr_wen(csr_wen),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(rdata0),
    .csr_illegal(ill0), .trap_vld(trap_vld), .trap_cause(trap_cause),
    .trap_pc(trap_pc), .trap_tval(trap_tval), .mret_vld(mret_vld),
    .instret_inc(instret_inc), .irq_ext(irq_ext), .irq_tmr(irq_tmr), .irq_sw(irq_sw),
    .trap_vector(tvec0), .epc_out(epc0), .irq_pend(pend0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_mie, m_mpie;
  logic [31:0] m_mie_en, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_mip;
  logic [63:0] m_cycle, m_instret;
  logic [31:0] m_rdata;
  bit          m_ill;

  function automatic bit m_read(input logic [11:0] a, output logic [31:0] v);
    v = 32'h0;
    case (a)
      12'h300: v = 32'h1800 | (m_mpie ? 32'h80 : 32'h0) | (m_mie ? 32'h8 : 32'h0);
      12'h301: v = 32'h4000_0100;
      12'h304: v = m_mie_en;
      12'h305: v = m_mtvec;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h343: v = m_mtval;
      12'h344: v = m_mip;
      12'hF14: v = HART_V;
      12'hB00: v = m_cycle[31:0];
      12'hB80: v = m_cycle[63:32];
      12'hB02: v = m_instret[31:0];
      12'hB82: v = m_instret[63:32];
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  function automatic bit m_ro(input logic [11:0] a);
    return (a >= 12'hC00) || a == 12'h301 || a == 12'h344;
  endfunction

  function automatic bit m_pend();
    return m_mie && ((m_mip & m_mie_en) != 32'h0);
  endfunction

  function automatic logic [31:0] m_tvec(input logic [31:0] cause);
    logic [31:0] base;
    base = m_mtvec & ~32'h3;
    if (m_mtvec[1:0] == 2'b01 && cause[31]) return base + 32'd4 * cause[4:0];
    return base;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit o_mie, o_mpie, cw, iw, impl, ill, wr;
    logic [31:0] ov, nv;
    if (!rst_n) begin
      m_mie = 0; m_mpie = 0; m_mie_en = 0; m_mtvec = MTVEC_RST_V; m_mscratch = 0;
      m_mepc = 0; m_mcause = 0; m_mtval = 0; m_mip = 0; m_cycle = 0; m_instret = 0;
      m_rdata = 0; m_ill = 0;
    end else begin
      o_mie = m_mie; o_mpie = m_mpie; cw = 0; iw = 0;
      if (csr_vld) begin
        wr   = csr_wen && csr_op != 2'b00;
        impl = m_read(csr_addr, ov);
        ill  = !impl || (wr && m_ro(csr_addr));
        m_rdata = ill ? 32'h0 : ov;
        m_ill   = ill;
        if (!ill && wr) begin
          nv = (csr_op == 2'b01) ? csr_wdata :
               (csr_op == 2'b10) ? (ov | csr_wdata) : (ov & ~csr_wdata);
          case (csr_addr)
            12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
            12'h304: m_mie_en   = nv & 32'h888;
            12'h305: m_mtvec    = nv[1] ? (nv & ~32'h3) : nv;
            12'h340: m_mscratch = nv;
            12'h341: m_mepc     = nv & ~32'h3;
            12'h342: m_mcause   = nv;
            12'h343: m_mtval    = nv;
            12'hB00: begin m_cycle[31:0]    = nv; cw = 1; end
            12'hB80: begin m_cycle[63:32]   = nv; cw = 1; end
            12'hB02: begin m_instret[31:0]  = nv; iw = 1; end
            12'hB82: begin m_instret[63:32] = nv; iw = 1; end
            default: ;
          endcase
        end
      end
      if (!cw) m_cycle = m_cycle + 1;
      if (!iw && instret_inc) m_instret = m_instret + 1;
      m_mip = (irq_ext ? 32'h800 : 32'h0) | (irq_tmr ? 32'h80 : 32'h0) | (irq_sw ? 32'h8 : 32'h0);
      if (trap_vld) begin
        m_mepc = trap_pc & ~32'h3; m_mcause = trap_cause; m_mtval = trap_tval;
        m_mpie = o_mie; m_mie = 0;
      end else if (mret_vld) begin
        m_mie = o_mpie; m_mpie = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("cmp_rdata",   csr_rdata,   m_rdata);
      chk("cmp_illegal", csr_illegal, m_ill);
      chk("cmp_epc",     epc_out,     m_mepc);
      chk("cmp_pend",    irq_pend,    m_pend());
      chk("cmp_tvec",    trap_vector, m_tvec(trap_cause));
    end
  end

  // ---------------- stimulus ----------------
  task automatic acc(input logic [1:0] op, input logic wen, input logic [11:0] a,
                     input logic [31:0] wd, output logic [31:0] rd, output logic il);
    csr_vld = 1'b1; csr_op = op; csr_wen = wen; csr_addr = a; csr_wdata = wd;
    @(posedge clk); #1;
    rd = csr_rdata; il = csr_illegal;
    csr_vld = 1'b0; csr_wen = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] r; logic i;
    acc(2'b10, 1'b0, a, 32'h0, r, i);
    chk(name, r, exp);
  endtask

  task automatic wr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd);
    logic [31:0] r; logic i;
    acc(op, 1'b1, a, wd, r, i);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r; logic i;
    csr_vld = 0; csr_op = 0; csr_wen = 0; csr_addr = 0; csr_wdata = 0;
    trap_vld = 0; trap_cause = 0; trap_pc = 0; trap_tval = 0; mret_vld = 0;
    instret_inc = 0; irq_ext = 0; irq_tmr = 0; irq_sw = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk_on = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("rst_rdata", csr_rdata, 0);
    chk("rst_illegal", csr_illegal, 0);
    chk("rst_pend", irq_pend, 0);
    rst_n = 1'b1;

    // mtvec reset value and RMW
    rd_chk("mtvec_rst", 12'h305, 32'h80);
    acc(2'b01, 1, 12'h305, 32'h8000_0101, r, i); chk("mtvec_rw_old", r, 32'h80);
    rd_chk("mtvec_rw", 12'h305, 32'h8000_0101);
    acc(2'b11, 1, 12'h305, 32'h1, r, i); chk("mtvec_rc_old", r, 32'h8000_0101);
    rd_chk("mtvec_rc", 12'h305, 32'h8000_0100);
    wr(2'b01, 12'h305, 32'h102);
    rd_chk("mtvec_mode10", 12'h305, 32'h100);
    wr(2'b01, 12'h305, 32'h101);

    // trap entry and MRET
    acc(2'b10, 1, 12'h300, 32'h8, r, i); chk("mstatus_old", r, 32'h1800);
    rd_chk("mstatus_mie", 12'h300, 32'h1808);
    trap_cause = 32'h2; #1 chk("tvec_exc", trap_vector, 32'h100);
    trap_cause = 32'h8000_0007; trap_pc = 32'h1236; trap_tval = 32'h0;
    #1 chk("tvec_irq", trap_vector, 32'h11C);
    trap_vld = 1'b1; @(posedge clk); #1; trap_vld = 1'b0;
    chk("trap_epc", epc_out, 32'h1234);
    rd_chk("trap_mstatus", 12'h300, 32'h1880);
    rd_chk("trap_mcause", 12'h342, 32'h8000_0007);
    rd_chk("trap_mepc", 12'h341, 32'h1234);
    mret_vld = 1'b1; @(posedge clk); #1; mret_vld = 1'b0;
    rd_chk("mret_mstatus", 12'h300, 32'h1888);

    // interrupts
    wr(2'b01, 12'h304, 32'hFFFF_FFFF);
    rd_chk("mie_mask", 12'h304, 32'h888);
    wr(2'b01, 12'h304, 32'h800);
    irq_tmr = 1'b1; idle(2); chk("pend_masked", irq_pend, 0);
    irq_tmr = 1'b0; idle(1);
    irq_ext = 1'b1; idle(1); chk("pend_ext", irq_pend, 1);
    irq_ext = 1'b0;
    rd_chk("mip_ext", 12'h344, 32'h800);
    irq_ext = 1'b1; idle(1); chk("pend_ext2", irq_pend, 1);
    wr(2'b11, 12'h300, 32'h8);
    chk("pend_mie_off", irq_pend, 0);
    irq_ext = 1'b0;

    // illegal accesses
    acc(2'b01, 1, 12'hF14, 32'h1, r, i); chk("hartid_w_ill", i, 1); chk("hartid_w_rd", r, 0);
    acc(2'b10, 0, 12'hF14, 32'h0, r, i); chk("hartid_rd", r, HART_V); chk("hartid_rd_ill", i, 0);
    acc(2'b10, 0, 12'h301, 32'h0, r, i); chk("misa_rd", r, 32'h4000_0100); chk("misa_rd_ill", i, 0);
    acc(2'b01, 1, 12'h301, 32'h0, r, i); chk("misa_w_ill", i, 1);
    acc(2'b10, 0, 12'h7C0, 32'h0, r, i); chk("unimpl_ill", i, 1); chk("unimpl_rd", r, 0);
    acc(2'b01, 1, 12'h344, 32'hFFF, r, i); chk("mip_w_ill", i, 1);

    // counters
    wr(2'b01, 12'hB00, 32'hFFFF_FFFE);
    wr(2'b01, 12'hB80, 32'h0);
    rd_chk("mcycle_lo", 12'hB00, 32'hFFFF_FFFE);
    rd_chk("mcycleh_0", 12'hB80, 32'h0);
    rd_chk("mcycleh_carry", 12'hB80, 32'h1);
    wr(2'b01, 12'hB02, 32'h0);
    wr(2'b01, 12'hB82, 32'h0);
    for (int k = 0; k < 5; k++) begin
      instret_inc = 1'b1; idle(1); instret_inc = 1'b0; idle(1);
    end
    rd_chk("minstret_5", 12'hB02, 32'h5);
    instret_inc = 1'b1;
    wr(2'b01, 12'hB02, 32'hA);
    instret_inc = 1'b0;
    rd_chk("minstret_wr_supp", 12'hB02, 32'hA);
    rd_chk("minstreth", 12'hB82, 32'h0);
    acc(2'b10, 0, 12'hB00, 32'h0, r, i);
    chk("cnt0_ill", ill0, 1); chk("cnt0_rd", rdata0, 0);

    // simultaneous events
    trap_cause = 32'h2; trap_pc = 32'h5679; trap_tval = 32'h77;
    trap_vld = 1'b1;
    wr(2'b01, 12'h341, 32'hAAAA_AAA8);
    trap_vld = 1'b0;
    chk("trap_vs_wr_epc", epc_out, 32'h5678);
    rd_chk("trap_vs_wr_mepc", 12'h341, 32'h5678);
    wr(2'b10, 12'h300, 32'h8);
    trap_vld = 1'b1; mret_vld = 1'b1; idle(1); trap_vld = 1'b0; mret_vld = 1'b0;
    rd_chk("trap_vs_mret", 12'h300, 32'h1880);

    // reset in the middle of an access
    wr(2'b10, 12'h300, 32'h8);
    irq_ext = 1'b1;
    wr(2'b01, 12'h340, 32'h1234_5678);
    rd_chk("mscratch", 12'h340, 32'h1234_5678);
    chk("pend_pre_rst", irq_pend, 1);
    csr_vld = 1'b1; csr_op = 2'b01; csr_wen = 1'b1; csr_addr = 12'h340; csr_wdata = 32'hDEAD_BEEF;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_rdata", csr_rdata, 0);
    chk("midrst_illegal", csr_illegal, 0);
    chk("midrst_pend", irq_pend, 0);
    chk("midrst_epc", epc_out, 0);
    chk("midrst_tvec", trap_vector, 32'h80);
    csr_vld = 1'b0; csr_wen = 1'b0; irq_ext = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    rd_chk("mscratch_after_rst", 12'h340, 32'h0);
    rd_chk("mstatus_after_rst", 12'h300, 32'h1800);
    rd_chk("mtvec_after_rst", 12'h305, 32'h80);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_unit.md
# csr_unit

Machine-mode CSR unit, successor to the fixed 32-bit CSR register file. It is parametrised in data width and optional counters, and adds:
- atomic CSRRW/CSRRS/CSRRC read-modify-write;
- hardware trap entry and MRET state sequencing;
- interrupt pending/enable evaluation;
- 64-bit mcycle/minstret counters;
- illegal-access detection.

It sits beside the EX stage. The decoder supplies CSR requests, and the trap controller supplies trap/mret events.

## Interface
- XLEN, 32: data width; 32 only in this revision, parameter kept for package consistency.
- CNT_EN, 1: 1 = mcycle/minstret (+h) implemented; 0 = those addresses are illegal.
- MTVEC_RST, 32'h0000_0000: reset value of mtvec.
- HART_ID, 0: value returned by mhartid.

Ports:
- clk  in  1  clock; one clock domain.
- rst_n  in  1  reset; asynchronous and active-low.
- csr_vld  in  1  CSR access request this cycle.
- csr_op  in  2  01 RW, 10 RS, 11 RC; 00 reserved, treated as read-only.
- csr_wen  in  1  write intent; the decoder clears it for RS/RC with rs1 = x0.
- csr_addr  in  12  CSR address.
- csr_wdata  in  XLEN  rs1/uimm operand.
- csr_rdata  out  XLEN  old CSR value, registered.
- csr_illegal  out  1  registered, aligned with csr_rdata.
- trap_vld  in  1  take trap.
- trap_cause  in  XLEN  mcause value; bit 31 = interrupt.
- trap_pc  in  XLEN  faulting or next PC.
- trap_tval  in  XLEN  mtval value.
- mret_vld  in  1  execute MRET.
- instret_inc  in  1  one instruction retired.
- irq_ext, irq_tmr, irq_sw  in  1 each  level interrupt lines, synchronous to clk.
- trap_vector  out  XLEN  combinational target PC for the current trap_cause.
- epc_out  out  XLEN  mepc.
- irq_pend  out  1  interrupt ready to be taken.

## Operation
- **Implemented CSRs:**
  - mstatus: only MIE(3), MPIE(7) and MPP(12:11) are storage; MPP is hardwired 2'b11; other bits read 0.
  - misa: read-only, 32'h4000_0100.
  - mie: bits 3/7/11 writable.
  - mtvec: mode bits [1:0] are 00 or 01; writes of 1x are stored as 00.
  - mscratch, mepc (bits [1:0] read 0), mcause, mtval.
  - mip: read-only; MSIP/MTIP/MEIP = registered irq_sw/tmr/ext.
  - mhartid: read-only.
  - mcycle, mcycleh, minstret, minstreth: only when CNT_EN = 1.
- **Read-modify-write:** new = wdata (RW), old | wdata (RS), old & ~wdata (RC). It is committed only when csr_vld && csr_wen && !illegal.
- **Illegal access:** any of the following sets csr_illegal, blocks state change, and returns rdata = 0:
  - unimplemented address;
  - csr_wen to a read-only address (addr[11:10] = 11, or misa/mip).
- **Trap entry (trap_vld):**
  - mepc <= trap_pc & ~3; mcause <= trap_cause; mtval <= trap_tval;
  - MPIE <= MIE; MIE <= 0.
- **MRET (mret_vld):** MIE <= MPIE; MPIE <= 1.
- **Priority per register in one cycle:** trap_vld > mret_vld > CSR write. trap_vld and mret_vld together means the trap wins and mret is ignored.
- **trap_vector:**
  - if mtvec mode = 01 and trap_cause[31] = 1: (mtvec & ~3) + 4·cause[4:0];
  - otherwise: mtvec & ~3.
- **irq_pend:** MIE && |(mip & mie), computed from registered state.
- **Counters:**
  - mcycle (64-bit) increments every cycle; minstret increments when instret_inc.
  - Wrap from 2^64-1 to 0.
  - A CSR write to the low or high half in the same cycle replaces that half and suppresses the increment of the whole counter for that cycle.

## Timing
- **Reset values:** while rst_n is low, all state clears asynchronously:
  - mtvec = MTVEC_RST; all other storage = 0 (MPP reads 11);
  - csr_rdata = 0, csr_illegal = 0, irq_pend = 0.
- **Access latency:** csr_rdata and csr_illegal are valid one cycle after csr_vld. The value is pre-write, so RMW is atomic. When csr_vld is low, csr_rdata holds its last value.
- **Back-to-back accesses:** a write in cycle N is visible to a read issued in cycle N+1.
- **Trap/MRET:** updates appear in the CSR registers at the next edge. irq_pend reflects the new MIE one cycle later.
- **Interrupt lines:** irq_* lines reach mip one cycle after they are asserted and reach irq_pend on the same cycle as mip.
- **Reset mid-access:** the access is discarded and no write takes place.

## Structure
- **Shared package `csr_pkg`:**
  - CSR address constants;
  - csr_op encodings;
  - mstatus/mip bit indices;
  - interrupt cause codes (3/7/11);
  - misa constant.
- **Sub-module `csr_counter64`:**
  - inputs: inc, wr_lo, wr_hi, wdata;
  - output: q[63:0];
  - instantiated twice (mcycle, minstret) under a CNT_EN generate block.

## Test plan
- **Reset and mtvec RMW:** after reset, read mtvec -> MTVEC_RST. CSRRW mtvec 0x8000_0101 -> next read 0x8000_0101. CSRRC with wdata 0x1 -> returns 0x8000_0101, then reads 0x8000_0100.
- **Trap and MRET:** set MIE. trap_vld with cause 0x8000_0007, pc 0x1236, tval 0 -> mepc = 0x1234, MIE = 0, MPIE = 1. With mtvec 0x100 in mode 01, trap_vector = 0x11C. mret -> MIE = 1.
- **Interrupt pending:** mie = 0x800, MIE = 1, pulse irq_ext -> mip = 0x800 after 1 cycle, irq_pend = 1. Clear MIE -> irq_pend = 0.
- **Illegal accesses:** CSRRW mhartid -> csr_illegal = 1, rdata = 0. CSRRS misa with csr_wen = 0 -> legal, 0x4000_0100. Address 0x7C0 -> illegal.
- **Counters:** write mcycle = 0xFFFF_FFFE, then mcycleh = 0 -> low half carries into mcycleh = 1 two cycles later. minstret counts exactly the number of instret_inc pulses. With CNT_EN = 0, a read of mcycle is illegal.
- **Simultaneous events:** trap_vld with a CSRRW to mepc in the same cycle -> mepc = trap value. Async reset asserted mid-access -> all outputs 0 immediately.
